// File: rtl/instr_issue_window_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_window_pkg
// Purpose  : Shared types and sizing constants for the instruction issue
//            window. It stands in for the core-wide decoded-instruction
//            definitions and adds the default window depth used by the core.
// Contents : NUM_REGS, NUM_OUTSTANDING, ISSUE_WINDOW_DEPTH, decoded_instr_t,
//            reg_bit() helper
// Revision : 1.0 - initial release
// ============================================================================
package instr_issue_window_pkg;

    localparam int NUM_REGS           = 32;
    localparam int NUM_OUTSTANDING    = 3;
    // One extra slot so a full scoreboard can still expose a launchable
    // instruction to the execution side.
    localparam int ISSUE_WINDOW_DEPTH = NUM_OUTSTANDING + 1;
    localparam int REG_IDX_W          = $clog2(NUM_REGS);
    localparam int TAG_W              = 16;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;       // opaque payload carried to execution
        logic [REG_IDX_W-1:0] rd;        // destination register
        logic [NUM_REGS-1:0]  reg_req;   // registers read or written
        logic                 mem_op;    // memory access, issued in order
        logic                 blocking;  // serialising: only launches as oldest
    } decoded_instr_t;

    // One-hot register mask for a register index.
    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_issue_window_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_window_if
// Purpose  : Decode-side and execution-side handshake bundle of the
//            instruction issue window.
// Ports    : clear_i, instr_in_i/_valid_i/_ready_o (decode side),
//            locks_i (scoreboard), instr_out_o/_valid_o/_ready_i
//            (execution side), count_o (occupancy)
// Modports : master - the environment driving the window
//            slave  - the issue window itself
// Revision : 1.0 - initial release
// ============================================================================
interface instr_issue_window_if
    import instr_issue_window_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter int  NUM_REGS = instr_issue_window_pkg::NUM_REGS,
    parameter type instr_t  = instr_issue_window_pkg::decoded_instr_t
);

    logic                         clear_i;
    instr_t                       instr_in_i;
    logic                         instr_in_valid_i;
    logic                         instr_in_ready_o;
    logic [NUM_REGS-1:0]          locks_i;
    instr_t                       instr_out_o;
    logic                         instr_out_valid_o;
    logic                         instr_out_ready_i;
    logic [$clog2(DEPTH+1)-1:0]   count_o;

    modport master (
        output clear_i, instr_in_i, instr_in_valid_i, locks_i, instr_out_ready_i,
        input  instr_in_ready_o, instr_out_o, instr_out_valid_o, count_o
    );

    modport slave (
        input  clear_i, instr_in_i, instr_in_valid_i, locks_i, instr_out_ready_i,
        output instr_in_ready_o, instr_out_o, instr_out_valid_o, count_o
    );

endinterface
`default_nettype wire

// File: rtl/issue_window_select.sv
`default_nettype none
// ============================================================================
// Module   : issue_window_select
// Purpose  : Purely combinational oldest-ready picker over the issue window
//            slots. Scans oldest to youngest, accumulating the destination
//            registers of skipped entries as extra locks, tracking whether an
//            older memory op was skipped, and stopping at a skipped
//            serialising instruction.
// Ports    : i_slots (slot array, 0 = oldest), i_count (valid slots),
//            i_locks (scoreboard locks), o_sel_idx, o_sel_valid
// Revision : 1.0 - initial release
// ============================================================================
module issue_window_select
    import instr_issue_window_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter int  NUM_REGS = instr_issue_window_pkg::NUM_REGS,
    parameter type instr_t  = instr_issue_window_pkg::decoded_instr_t
) (
    input  instr_t                       i_slots [DEPTH],
    input  logic [$clog2(DEPTH+1)-1:0]   i_count,
    input  logic [NUM_REGS-1:0]          i_locks,
    output logic [$clog2(DEPTH)-1:0]     o_sel_idx,
    output logic                         o_sel_valid
);

    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam int c_idx_w = $clog2(DEPTH);

    logic [NUM_REGS-1:0] w_mask;
    logic                w_mem_seen;
    logic                w_stop;
    logic                w_found;
    logic                w_elig;
    logic [c_idx_w-1:0]  w_idx;
    logic                w_unused_slot_bits;

    always_comb begin
        w_mask     = i_locks;
        w_mem_seen = 1'b0;
        w_stop     = 1'b0;
        w_found    = 1'b0;
        w_elig     = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_stop && !w_found && (c_cnt_w'(i) < i_count)) begin
                w_elig = ((i_slots[i].reg_req & w_mask) == '0)
                      && (!i_slots[i].blocking || (i == 0))
                      && (!i_slots[i].mem_op   || !w_mem_seen);
                if (w_elig) begin
                    w_found = 1'b1;
                    w_idx   = c_idx_w'(i);
                end else begin
                    // A skipped entry will write rd later: younger readers
                    // and writers of rd must wait for it.
                    w_mask[i_slots[i].rd] = 1'b1;
                    if (i_slots[i].mem_op) begin
                        w_mem_seen = 1'b1;
                    end
                    if (i_slots[i].blocking) begin
                        w_stop = 1'b1;
                    end
                end
            end
        end
    end

    assign o_sel_idx   = w_idx;
    assign o_sel_valid = w_found;

    // Payload fields are not inspected by the picker.
    always_comb begin
        w_unused_slot_bits = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_unused_slot_bits = w_unused_slot_bits ^ (^i_slots[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_issue_window.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_window
// Purpose  : DEPTH-entry age-ordered buffer between decode and execution.
//            Each cycle the oldest instruction whose operands are free is
//            offered for launch, honouring scoreboard locks, in-window
//            RAW/WAW hazards, memory ordering and serialising instructions.
//            Launched slots are compacted so slot 0 is always the oldest.
// Ports    : clk_i, rst_ni (synchronous, active-low),
//            bus (instr_issue_window_if.slave): clear_i, instr_in_*,
//            locks_i, instr_out_*, count_o
// Options  : INSTR_ISSUE_WINDOW_BYPASS_EN - when defined, an instruction
//            arriving at an empty window with free operands is offered on
//            instr_out_o in the same cycle and is not stored if consumed.
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue_window
    import instr_issue_window_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter type instr_t  = instr_issue_window_pkg::decoded_instr_t,
    parameter int  NUM_REGS = instr_issue_window_pkg::NUM_REGS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    instr_issue_window_if.slave bus
);

    localparam int                  c_cnt_w = $clog2(DEPTH+1);
    localparam int                  c_idx_w = $clog2(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);

    instr_t              r_slots [DEPTH];
    logic [c_cnt_w-1:0]  r_count;

    instr_t              w_slots_nxt [DEPTH];
    instr_t              w_slot_out;
    instr_t              w_out;
    logic                w_active;
    logic                w_in_ready;
    logic                w_sel_valid;
    logic [c_idx_w-1:0]  w_sel_idx;
    logic                w_byp;
    logic                w_out_valid;
    logic                w_launch_slot;
    logic                w_enq;
    logic [c_cnt_w-1:0]  w_wr_idx;

    assign w_active   = rst_ni & ~bus.clear_i;
    // Credit depends on the registered count only.
    assign w_in_ready = w_active & (r_count < c_depth);

    issue_window_select #(
        .DEPTH    (DEPTH),
        .NUM_REGS (NUM_REGS),
        .instr_t  (instr_t)
    ) u_select (
        .i_slots     (r_slots),
        .i_count     (r_count),
        .i_locks     (bus.locks_i),
        .o_sel_idx   (w_sel_idx),
        .o_sel_valid (w_sel_valid)
    );

    always_comb begin
        w_slot_out = r_slots[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (c_idx_w'(i) == w_sel_idx) begin
                w_slot_out = r_slots[i];
            end
        end
    end

`ifdef INSTR_ISSUE_WINDOW_BYPASS_EN
    assign w_byp = w_active & (r_count == '0) & bus.instr_in_valid_i
                 & ((bus.instr_in_i.reg_req & bus.locks_i) == '0);
    assign w_out = w_byp ? bus.instr_in_i : w_slot_out;
`else
    assign w_byp = 1'b0;
    assign w_out = w_slot_out;
`endif

    assign w_out_valid   = (w_sel_valid & w_active) | w_byp;
    assign w_launch_slot = w_sel_valid & w_active & bus.instr_out_ready_i & ~w_byp;
    // A bypassed instruction that is consumed never occupies a slot.
    assign w_enq         = bus.instr_in_valid_i & w_in_ready
                         & ~(w_byp & bus.instr_out_ready_i);
    // Tail position after the launched slot has been squeezed out.
    assign w_wr_idx      = r_count - c_cnt_w'(w_launch_slot);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_slots_nxt[i] = r_slots[i];
        end
        if (w_launch_slot) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                if (c_idx_w'(i) >= w_sel_idx) begin
                    w_slots_nxt[i] = r_slots[i+1];
                end
            end
        end
        if (w_enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (c_cnt_w'(i) == w_wr_idx) begin
                    w_slots_nxt[i] = bus.instr_in_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.clear_i) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_launch_slot);
        end
    end

    // Payload storage needs no reset: only slots below r_count are observed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_slots[i] <= w_slots_nxt[i];
        end
    end

    assign bus.instr_in_ready_o  = w_in_ready;
    assign bus.instr_out_o       = w_out;
    assign bus.instr_out_valid_o = w_out_valid;
    assign bus.count_o           = rst_ni ? r_count : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_issue_window
// Purpose  : Self-checking bench for instr_issue_window: directed hazard
//            scenarios with literal expectations, then randomized traffic
//            compared every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issue_window;
    import instr_issue_window_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_issue_window_if #(
        .DEPTH    (DEPTH),
        .NUM_REGS (NUM_REGS),
        .instr_t  (decoded_instr_t)
    ) bus ();

    instr_issue_window #(
        .DEPTH    (DEPTH),
        .instr_t  (decoded_instr_t),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    decoded_instr_t q[$];   // model contents, index 0 = oldest

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic decoded_instr_t mk(input int rd, input int req, input bit mem,
                                          input bit blk, input int tag);
        decoded_instr_t t;
        t = '0;
        t.rd = REG_IDX_W'(rd);
        if (req >= 0) t.reg_req[req] = 1'b1;
        t.mem_op   = mem;
        t.blocking = blk;
        t.tag      = TAG_W'(tag);
        return t;
    endfunction

    function automatic logic [NUM_REGS-1:0] L(input int r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    // Entry j launches iff it is the first entry whose own rules hold, where
    // everything older than j counts as stalled: older destinations act as
    // locks, any older memory op holds memory ops, any older serialising
    // instruction holds everything.
    function automatic int model_pick(input decoded_instr_t qq[$], input logic [NUM_REGS-1:0] lk);
        logic [NUM_REGS-1:0] older_rd;
        bit older_mem, older_blk;
        for (int j = 0; j < qq.size(); j++) begin
            older_rd  = '0;
            older_mem = 1'b0;
            older_blk = 1'b0;
            for (int k = 0; k < j; k++) begin
                older_rd[qq[k].rd] = 1'b1;
                older_mem = older_mem | qq[k].mem_op;
                older_blk = older_blk | qq[k].blocking;
            end
            if (older_blk) return -1;
            if ((qq[j].reg_req & (lk | older_rd)) != '0) continue;
            if (qq[j].blocking && j != 0) continue;
            if (qq[j].mem_op && older_mem) continue;
            return j;
        end
        return -1;
    endfunction

    task automatic drive(input bit v, input decoded_instr_t ins, input logic [NUM_REGS-1:0] lk,
                         input bit rdy, input bit clr);
        bus.instr_in_valid_i  = v;
        bus.instr_in_i        = ins;
        bus.locks_i           = lk;
        bus.instr_out_ready_i = rdy;
        bus.clear_i           = clr;
        #2;
    endtask

    // Compare all outputs against the model, advance the model, cross the edge.
    task automatic cycle();
        int sel;
        bit act, exp_rdy, exp_vld, byp, launch, enq;
        decoded_instr_t exp_out;
        act     = rst_n && !bus.clear_i;
        exp_rdy = act && (q.size() < DEPTH);
        sel     = act ? model_pick(q, bus.locks_i) : -1;
        byp     = 1'b0;
`ifdef INSTR_ISSUE_WINDOW_BYPASS_EN
        byp = act && (q.size() == 0) && bus.instr_in_valid_i
              && ((bus.instr_in_i.reg_req & bus.locks_i) == '0);
`endif
        exp_vld = (sel >= 0) || byp;
        check("in_ready",  64'(bus.instr_in_ready_o),  64'(exp_rdy));
        check("out_valid", 64'(bus.instr_out_valid_o), 64'(exp_vld));
        check("count",     64'(bus.count_o),           64'(rst_n ? q.size() : 0));
        if (exp_vld) begin
            exp_out = byp ? bus.instr_in_i : q[sel];
            check("instr_out", 64'(bus.instr_out_o), 64'(exp_out));
        end
        launch = exp_vld && bus.instr_out_ready_i;
        enq    = bus.instr_in_valid_i && exp_rdy && !(byp && launch);
        if (!act) begin
            q.delete();
        end else begin
            if (launch && !byp) q.delete(sel);
            if (enq) q.push_back(bus.instr_in_i);
        end
        @(posedge clk);
        #1;
    endtask

    decoded_instr_t z;
    decoded_instr_t ri;
    logic [NUM_REGS-1:0] lk;

    initial begin
        z = '0;
        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive(0, z, '0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            check("rst_no_x", 64'($isunknown({bus.instr_in_ready_o, bus.instr_out_valid_o, bus.count_o})), 64'(0));
            check("rst_ready", 64'(bus.instr_in_ready_o), 64'(0));
            check("rst_valid", 64'(bus.instr_out_valid_o), 64'(0));
            check("rst_count", 64'(bus.count_o), 64'(0));
            cycle();
        end
        rst_n = 1'b1;
        drive(0, z, '0, 1, 0);
        check("post_rst_ready", 64'(bus.instr_in_ready_o), 64'(1));
        cycle();

        // ---------------- lock stall ----------------
        drive(1, mk(1, 5, 0, 0, 'hA1), L(5), 1, 0); cycle();
        drive(1, mk(7, 6, 0, 0, 'hB1), L(5), 1, 0);
        check("lock_hold_valid", 64'(bus.instr_out_valid_o), 64'(0));
        cycle();
        drive(0, z, L(5), 1, 0);
        check("lock_b_valid", 64'(bus.instr_out_valid_o), 64'(1));
        check("lock_b_tag", 64'(bus.instr_out_o.tag), 64'('hB1));
        cycle();
        drive(0, z, '0, 1, 0);
        check("lock_a_tag", 64'(bus.instr_out_o.tag), 64'('hA1));
        cycle();

        // ---------------- RAW inside the window ----------------
        drive(1, mk(3, 1, 0, 0, 'hA2), L(1), 1, 0); cycle();
        drive(1, mk(4, 3, 0, 0, 'hB2), L(1), 1, 0); cycle();
        drive(0, z, L(1), 1, 0);
        check("raw_hold_valid", 64'(bus.instr_out_valid_o), 64'(0));
        cycle();
        drive(0, z, '0, 1, 0);
        check("raw_a_tag", 64'(bus.instr_out_o.tag), 64'('hA2));
        cycle();
        drive(0, z, '0, 1, 0);
        check("raw_b_tag", 64'(bus.instr_out_o.tag), 64'('hB2));
        cycle();

        // ---------------- memory ordering ----------------
        drive(1, mk(9, 8, 1, 0, 'hA3), L(8), 1, 0);   cycle();
        drive(1, mk(11, 10, 1, 0, 'hB3), L(8), 1, 0); cycle();
        drive(1, mk(13, 12, 0, 0, 'hC3), L(8), 1, 0); cycle();
        drive(0, z, L(8), 1, 0);
        check("mem_c_tag", 64'(bus.instr_out_o.tag), 64'('hC3));
        cycle();
        drive(0, z, L(8), 1, 0);
        check("mem_b_held", 64'(bus.instr_out_valid_o), 64'(0));
        cycle();
        drive(0, z, '0, 1, 0);
        check("mem_a_tag", 64'(bus.instr_out_o.tag), 64'('hA3));
        cycle();
        drive(0, z, '0, 1, 0);
        check("mem_b_tag", 64'(bus.instr_out_o.tag), 64'('hB3));
        cycle();

        // ---------------- serialising instruction ----------------
        drive(1, mk(15, 14, 0, 0, 'h54), L(14), 1, 0); cycle();
        drive(1, mk(16, -1, 0, 1, 'hA4), L(14), 1, 0); cycle();
        drive(1, mk(17, -1, 0, 0, 'hC4), L(14), 1, 0); cycle();
        drive(0, z, L(14), 1, 0);
        check("blk_hold_valid", 64'(bus.instr_out_valid_o), 64'(0));
        cycle();
        drive(0, z, '0, 1, 0);
        check("blk_s_tag", 64'(bus.instr_out_o.tag), 64'('h54));
        cycle();
        drive(0, z, '0, 1, 0);
        check("blk_a_tag", 64'(bus.instr_out_o.tag), 64'('hA4));
        cycle();
        drive(0, z, '0, 1, 0);
        check("blk_c_tag", 64'(bus.instr_out_o.tag), 64'('hC4));
        cycle();

        // ---------------- full and flush ----------------
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, mk(i + 1, -1, 0, 0, 'hF0 + i), '0, 0, 0); cycle();
        end
        drive(0, z, '0, 0, 0);
        check("full_count", 64'(bus.count_o), 64'(4));
        check("full_ready", 64'(bus.instr_in_ready_o), 64'(0));
        cycle();
        drive(1, mk(20, -1, 0, 0, 'hEE), '0, 1, 1);
        check("clr_ready", 64'(bus.instr_in_ready_o), 64'(0));
        check("clr_valid", 64'(bus.instr_out_valid_o), 64'(0));
        cycle();
        drive(0, z, '0, 1, 0);
        check("post_clr_count", 64'(bus.count_o), 64'(0));
        check("post_clr_ready", 64'(bus.instr_in_ready_o), 64'(1));
        check("post_clr_valid", 64'(bus.instr_out_valid_o), 64'(0));
        cycle();

        // ---------------- full with launch ----------------
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, mk(i + 1, -1, 0, 0, 'hD0 + i), '0, 0, 0); cycle();
        end
        drive(1, mk(21, -1, 0, 0, 'hDD), '0, 1, 0);
        check("fl_ready", 64'(bus.instr_in_ready_o), 64'(0));
        check("fl_tag", 64'(bus.instr_out_o.tag), 64'('hD0));
        cycle();
        drive(0, z, '0, 0, 0);
        check("fl_ready_next", 64'(bus.instr_in_ready_o), 64'(1));
        check("fl_count_next", 64'(bus.count_o), 64'(3));
        cycle();
        drive(0, z, '0, 0, 1); cycle();

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            lk = '0;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) lk[b] = 1'b1;
            end
            ri = '0;
            ri.rd = REG_IDX_W'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) ri.reg_req[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 1) == 1) ri.reg_req[$urandom_range(0, 7)] = 1'b1;
            ri.mem_op   = ($urandom_range(0, 3) == 0);
            ri.blocking = ($urandom_range(0, 9) == 0);
            ri.tag      = TAG_W'(n);
            drive(1'($urandom_range(0, 1)), ri, lk, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
